// File: rtl/axi_llc_lock_gate.sv
// Holds one LLC descriptor, waits for the lock box to report its line unlocked, strobes the lock, then forwards it.
// Latency accept -> lock_req 1 cycle -> out_valid 2 cycles; stalls in CHECK while locked_i, holds payload in SEND until out_ready_i.
module axi_llc_lock_gate #(
  parameter int unsigned IndexLength      = 8,
  parameter int unsigned SetAssociativity = 8,
  parameter int unsigned StallCntWidth    = 8,
  parameter int unsigned WatchdogThr      = 200
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        desc_valid_i,
  input  logic [IndexLength-1:0]      desc_index_i,
  input  logic [SetAssociativity-1:0] desc_way_i,
  output logic                        desc_ready_o,
  output logic [IndexLength-1:0]      lock_index_o,
  output logic [SetAssociativity-1:0] lock_way_o,
  output logic                        lock_req_o,
  input  logic                        locked_i,
  output logic                        out_valid_o,
  output logic [IndexLength-1:0]      out_index_o,
  output logic [SetAssociativity-1:0] out_way_o,
  input  logic                        out_ready_i,
  output logic [StallCntWidth-1:0]    max_stall_o,
  output logic                        watchdog_o
);

  typedef enum logic [1:0] {IDLE, CHECK, SEND} state_e;

  localparam logic [StallCntWidth-1:0] StallMax = '1;
  localparam logic [StallCntWidth-1:0] WdThr    = StallCntWidth'(WatchdogThr);

  state_e                        state_q, state_d;
  logic [IndexLength-1:0]        index_q;
  logic [SetAssociativity-1:0]   way_q;
  logic [StallCntWidth-1:0]      stall_cnt_q;
  logic [StallCntWidth-1:0]      max_stall_q;
  logic                          watchdog_q;
  logic                          accept;
  logic                          stall_inc;
  logic                          leave_check;

  always_comb begin
    state_d      = state_q;
    desc_ready_o = 1'b0;
    lock_req_o   = 1'b0;
    out_valid_o  = 1'b0;
    accept       = 1'b0;
    stall_inc    = 1'b0;
    leave_check  = 1'b0;
    unique case (state_q)
      IDLE: begin
        desc_ready_o = 1'b1;
        if (desc_valid_i) begin
          accept  = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (locked_i) begin
          stall_inc = 1'b1;
        end else begin
          lock_req_o  = 1'b1;
          leave_check = 1'b1;
          state_d     = SEND;
        end
      end
      SEND: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Handshake outputs are forced low for the whole reset cycle, not just after the edge.
    if (rst_i) begin
      desc_ready_o = 1'b0;
      lock_req_o   = 1'b0;
      out_valid_o  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      index_q     <= '0;
      way_q       <= '0;
      stall_cnt_q <= '0;
      max_stall_q <= '0;
      watchdog_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        index_q     <= desc_index_i;
        way_q       <= desc_way_i;
        stall_cnt_q <= '0;
      end else if (stall_inc && stall_cnt_q != StallMax) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (leave_check && stall_cnt_q > max_stall_q) begin
        max_stall_q <= stall_cnt_q;
      end
      if (stall_cnt_q >= WdThr) begin
        watchdog_q <= 1'b1;
      end
    end
  end

  assign lock_index_o = index_q;
  assign lock_way_o   = way_q;
  assign out_index_o  = index_q;
  assign out_way_o    = way_q;
  assign max_stall_o  = max_stall_q;
  assign watchdog_o   = watchdog_q;

endmodule

// File: tb/tb_axi_llc_lock_gate.sv
// Directed plus randomized descriptor traffic against a per-descriptor timing model of the lock gate.
module tb_axi_llc_lock_gate;

  localparam int SW   = 4;
  localparam int THR  = 3;
  localparam int MAXC = 15;

  logic           clk = 1'b0;
  logic           rst;
  logic           desc_valid;
  logic [7:0]     desc_index;
  logic [7:0]     desc_way;
  logic           desc_ready;
  logic [7:0]     lock_index;
  logic [7:0]     lock_way;
  logic           lock_req;
  logic           locked;
  logic           out_valid;
  logic [7:0]     out_index;
  logic [7:0]     out_way;
  logic           out_ready;
  logic [SW-1:0]  max_stall;
  logic           watchdog;

  int compared = 0;
  int mism     = 0;

  // expected registered state, maintained per descriptor
  logic [7:0]    e_idx, e_way;
  logic [SW-1:0] e_ms;
  logic          e_wd;

  axi_llc_lock_gate #(
    .IndexLength(8), .SetAssociativity(8), .StallCntWidth(SW), .WatchdogThr(THR)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .desc_valid_i(desc_valid), .desc_index_i(desc_index), .desc_way_i(desc_way),
    .desc_ready_o(desc_ready),
    .lock_index_o(lock_index), .lock_way_o(lock_way), .lock_req_o(lock_req),
    .locked_i(locked),
    .out_valid_o(out_valid), .out_index_o(out_index), .out_way_o(out_way),
    .out_ready_i(out_ready),
    .max_stall_o(max_stall), .watchdog_o(watchdog)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [7:0] r8();
    return 8'($urandom);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mism++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, then check every output.
  task automatic cyc(input logic dv, input logic [7:0] di, input logic [7:0] dw,
                     input logic lk, input logic ordy, input logic rs,
                     input logic edr, input logic elr, input logic eov);
    @(negedge clk);
    desc_valid = dv; desc_index = di; desc_way = dw;
    locked = lk; out_ready = ordy; rst = rs;
    #1;
    chk("desc_ready", 32'(desc_ready), 32'(edr));
    chk("lock_req",   32'(lock_req),   32'(elr));
    chk("out_valid",  32'(out_valid),  32'(eov));
    chk("lock_index", 32'(lock_index), 32'(e_idx));
    chk("lock_way",   32'(lock_way),   32'(e_way));
    chk("out_index",  32'(out_index),  32'(e_idx));
    chk("out_way",    32'(out_way),    32'(e_way));
    chk("max_stall",  32'(max_stall),  32'(e_ms));
    chk("watchdog",   32'(watchdog),   32'(e_wd));
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(rb(), r8(), r8(), 1'b1, rb(), 1'b1, 1'b0, 1'b0, 1'b0);
      e_idx = '0; e_way = '0; e_ms = '0; e_wd = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b0, r8(), r8(), rb(), rb(), 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // Descriptor held locked for k cycles after acceptance, then out_ready withheld for d cycles.
  // Counter reaches THR after THR stalls; watchdog is visible two cycles later, i.e. cycle THR+2 after accept.
  task automatic run_desc(input logic [7:0] idx, input logic [7:0] way, input int k, input int d);
    int j;
    cyc(1'b1, idx, way, rb(), rb(), 1'b0, 1'b1, 1'b0, 1'b0);
    e_idx = idx; e_way = way;
    for (j = 1; j <= k; j++) begin
      if (k >= THR && j >= THR + 2) e_wd = 1'b1;
      cyc(rb(), r8(), r8(), 1'b1, rb(), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    if (k >= THR && j >= THR + 2) e_wd = 1'b1;
    cyc(rb(), r8(), r8(), 1'b0, rb(), 1'b0, 1'b0, 1'b1, 1'b0);
    if ((k > MAXC ? MAXC : k) > int'(e_ms)) e_ms = SW'(k > MAXC ? MAXC : k);
    for (int s = 0; s <= d; s++) begin
      if (k >= THR && (k + 2 + s) >= THR + 2) e_wd = 1'b1;
      cyc(rb(), r8(), r8(), rb(), (s == d), 1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    rst = 1'b1; desc_valid = 1'b0; desc_index = '0; desc_way = '0;
    locked = 1'b0; out_ready = 1'b0;
    e_idx = '0; e_way = '0; e_ms = '0; e_wd = 1'b0;
    @(posedge clk);
    do_reset(3);
    idle(1);

    // basic pass-through, then downstream backpressure for 4 cycles
    run_desc(8'h12, 8'h04, 0, 0);
    idle(1);
    run_desc(8'h5A, 8'h80, 0, 4);
    idle(1);

    // reset while stalled in CHECK
    cyc(1'b1, 8'h77, 8'h10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    e_idx = 8'h77; e_way = 8'h10;
    cyc(1'b0, r8(), r8(), 1'b1, rb(), 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, r8(), r8(), 1'b1, rb(), 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset(2);
    idle(1);
    run_desc(8'h21, 8'h02, 1, 1);

    // watchdog after THR stall cycles, sticky past completion
    run_desc(8'h3C, 8'h08, THR, 2);
    idle(1);
    chk("watchdog_sticky", 32'(watchdog), 32'd1);

    run_desc(8'h33, 8'h01, 5, 0);
    idle(1);
    chk("max_stall_5", 32'(max_stall), 32'd5);

    run_desc(8'h44, 8'h20, 20, 1);
    idle(1);
    chk("max_stall_sat", 32'(max_stall), 32'd15);

    // reset while waiting in SEND
    cyc(1'b1, 8'h99, 8'h40, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    e_idx = 8'h99; e_way = 8'h40;
    cyc(1'b0, r8(), r8(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, r8(), r8(), rb(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    do_reset(2);
    idle(2);

    for (int n = 0; n < 40; n++) begin
      int k;
      k = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 4);
      run_desc(r8(), 8'(1 << $urandom_range(0, 7)), k, $urandom_range(0, 5));
      idle($urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule

// File: doc/axi_llc_lock_gate.md
AXI_LLC_LOCK_GATE -- requirements
Module: axi_llc_lock_gate

Interface
REQ-001 SHALL have parameter IndexLength, default 8, meaning cache-line index width in bits.
REQ-002 SHALL have parameter SetAssociativity, default 8, meaning way-indicator width in bits (one-hot way).
REQ-003 SHALL have parameter StallCntWidth, default 8, meaning width of the stall counters.
REQ-004 SHALL have parameter WatchdogThr, default 200, meaning stall cycles per descriptor at which watchdog_o sets; range 1..2^StallCntWidth-1.
REQ-005 SHALL have port clk_i, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port desc_valid_i, input, 1 bit: upstream descriptor valid.
REQ-008 SHALL have port desc_index_i, input, IndexLength bits: descriptor index.
REQ-009 SHALL have port desc_way_i, input, SetAssociativity bits: descriptor way.
REQ-010 SHALL have port desc_ready_o, output, 1 bit: descriptor accepted.
REQ-011 SHALL have port lock_index_o, output, IndexLength bits: lookup/lock index to the lock box.
REQ-012 SHALL have port lock_way_o, output, SetAssociativity bits: lookup/lock way to the lock box.
REQ-013 SHALL have port lock_req_o, output, 1 bit: one-cycle lock (filter increment) strobe.
REQ-014 SHALL have port locked_i, input, 1 bit: lock box reports line locked or filter full.
REQ-015 SHALL have ports out_valid_o (output, 1 bit), out_index_o (output, IndexLength bits), out_way_o (output, SetAssociativity bits) and out_ready_i (input, 1 bit): downstream descriptor handshake.
REQ-016 SHALL have port max_stall_o, output, StallCntWidth bits: largest per-descriptor stall seen.
REQ-017 SHALL have port watchdog_o, output, 1 bit: sticky starvation flag.

Function
REQ-018 SHALL implement FSM states IDLE, CHECK and SEND.
REQ-019 IDLE SHALL drive desc_ready_o=1; on desc_valid_i, capture index/way into payload register, clear stall counter, go to CHECK.
REQ-020 desc_ready_o SHALL be 1 only in IDLE; CHECK and SEND SHALL drive it to 0.
REQ-021 lock_index_o/lock_way_o SHALL always equal the payload register; out_index_o/out_way_o SHALL equal the same register.
REQ-022 CHECK with locked_i=1 SHALL hold state, lock_req_o=0, stall counter +1 saturating at 2^StallCntWidth-1.
REQ-023 CHECK with locked_i=0 SHALL assert lock_req_o for exactly that cycle, go to SEND.
REQ-024 lock_req_o SHALL never be asserted outside CHECK, and at most once per descriptor.
REQ-025 SEND SHALL drive out_valid_o=1; payload SHALL be stable while out_valid_o=1 and out_ready_i=0; on out_ready_i=1, go to IDLE.
REQ-026 Minimum latency: descriptor accepted cycle N -> lock_req_o cycle N+1 -> out_valid_o cycle N+2; throughput at most one descriptor per 3 cycles.
REQ-027 On leaving CHECK, max_stall_o SHALL update to max(max_stall_o, stall counter); comparison is unsigned.
REQ-028 watchdog_o SHALL set in the cycle after the stall counter reaches WatchdogThr; it SHALL stay set until reset.
REQ-029 A locked_i toggle in SEND or IDLE SHALL have no effect.

Reset
REQ-030 While rst_i=1 at a clock edge: state IDLE, payload 0, stall counter 0, max_stall_o 0, watchdog_o 0.
REQ-031 While rst_i=1: lock_req_o=0, out_valid_o=0, desc_ready_o=0; from the first cycle after reset release: desc_ready_o=1.
REQ-032 Reset asserted mid-CHECK or mid-SEND SHALL discard the descriptor and issue no lock_req_o.

Verification
REQ-033 Bench SHALL cover: desc index=0x12, way=0x04, locked_i=0, out_ready_i=1 -> lock_req_o at N+1 with 0x12/0x04; out_valid_o at N+2; desc_ready_o=1 at N+3.
REQ-034 Bench SHALL cover: locked_i=1 for 5 cycles after acceptance -> lock_req_o once at N+6; max_stall_o=5.
REQ-035 Bench SHALL cover: out_ready_i=0 for 4 cycles in SEND -> out_valid_o and payload stable; desc_ready_o=0 throughout.
REQ-036 Bench SHALL cover: WatchdogThr=3, locked_i held 1 -> watchdog_o=1 after 3 stall cycles; it stays 1 after the descriptor completes.
REQ-037 Bench SHALL cover: StallCntWidth=4, locked_i=1 for 20 cycles -> counter saturates and max_stall_o=15.
REQ-038 Bench SHALL cover: rst_i in CHECK with locked_i=1 -> no lock_req_o, outputs at reset values, new descriptor accepted after release.
